load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory stage of the RV32I hart: accepts one memory operation at a time from execute, performs byte/half/word alignment, and drives a latency-tolerant data-memory port with a request/ready and rvalid handshake. It returns sign- or zero-extended load data, or a trap, to writeback. Non-memory instructions pass through with their ALU result. It replaces the purely combinational dmem access in the hart's memory stage.

## Interface
Parameters:
- none (RV32I, XLEN fixed at 32)

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  reset; synchronous and active-high
- i_valid  in  1  execute presents an instruction
- o_ready  out  1  LSU can accept (state IDLE)
- i_ren  in  1  instruction is a load
- i_wen  in  1  instruction is a store (never set together with i_ren)
- i_funct3  in  3  access size/sign (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- i_addr  in  32  ALU result: byte address, or pass-through value
- i_wdata  in  32  rs2 data for stores
- i_rd  in  5  destination register
- o_valid  out  1  one-cycle pulse: result for writeback
- o_rd  out  5  destination (0 for stores and traps)
- o_rdata  out  32  load data, or pass-through value
- o_trap  out  1  misaligned access or illegal funct3
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_dmem_ren  out  1  read request
- o_dmem_wen  out  1  write request
- o_dmem_wdata  out  32  lane-shifted store data
- o_dmem_mask  out  4  byte-lane enables
- i_dmem_ready  in  1  memory accepts the request this cycle
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  32  read data word

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: accept on i_valid and o_ready, capturing all inputs.
  - Memory op, legal and aligned: go to REQ.
  - Trap: stay IDLE and pulse o_valid next cycle with o_trap=1, o_rd=0. No dmem request is ever issued.
  - Non-memory op: stay IDLE and pulse o_valid next cycle with o_rdata=i_addr, o_rd=i_rd.
- REQ: o_dmem_ren or o_dmem_wen is asserted, with addr, mask and wdata held stable until i_dmem_ready.
  - Store accepted: go to IDLE and pulse o_valid next cycle with o_rd=0.
  - Load accepted: go to WAIT.
- WAIT: on i_dmem_rvalid, go to IDLE and pulse o_valid next cycle with the extracted data and o_rd=captured rd.
- i_dmem_rvalid is ignored outside WAIT. Memory never asserts it in the same cycle as acceptance.
- Misaligned: half-word access with addr[0]=1; word access with addr[1:0]≠0.
- Illegal funct3: loads 3, 6, 7; stores ≥3.
- Mask:
  - byte: 1<<addr[1:0]
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1
  - word: 1111
- Store data: wdata << (8·addr[1:0]).
- Load data: rdata >> (8·addr[1:0]), then sign-extend (LB/LH) or zero-extend (LBU/LHU) from bit 7 or bit 15.

## Timing
- Reset values: state IDLE, o_ready=1, o_valid=0, o_trap=0, o_rd=0, o_rdata=0, o_dmem_ren=0, o_dmem_wen=0, o_dmem_addr=0, o_dmem_wdata=0, o_dmem_mask=0.
- All outputs are registered except o_ready, which is decoded from state.
- Latency, counted from the accept edge (cycle 0):
  - pass-through or trap: o_valid in cycle 1
  - store with immediate ready: request in cycle 1, o_valid in cycle 2
  - load: o_valid in the cycle after rvalid (min cycle 3)
- o_ready rises in the same cycle as o_valid for stores and loads, so back-to-back acceptance is allowed.
- Reset mid-operation (REQ or WAIT): the request drops the cycle after reset and the operation is discarded without o_valid. A late rvalid is then ignored.
- No downstream backpressure: writeback always consumes o_valid.

## Structure
- Shared package lsu_pkg: funct3 localparams and the state encoding (IDLE/REQ/WAIT).
- One combinational sub-module, lsu_align: computes mask, shifted wdata, misalign/illegal flag, and load extraction.
- The FSM and registers stay in load_store_unit.

## Test plan
- SB at addr 0x00001003, wdata 0x000000AB, ready immediate -> o_dmem_addr 0x00001000, mask 1000, wdata 0xAB000000, o_valid at cycle 2 with o_rd=0.
- LH at 0x00002002, rvalid at cycle 2 with rdata 0x8001_1234 -> o_rdata 0xFFFF8001 at cycle 3. Same access as LHU -> 0x00008001.
- LW at 0x00003001 -> o_trap=1 and o_valid at cycle 1; o_dmem_ren never asserted.
- SW with i_dmem_ready low for 3 cycles -> wen, addr and wdata stable, o_ready=0, new i_valid ignored. o_valid arrives one cycle after ready.
- Reset asserted during WAIT, rvalid arrives afterwards -> no o_valid, all outputs at reset values, o_ready=1.
- Pass-through (ren=wen=0) with addr 0x12345678, rd=5 -> o_valid at cycle 1 with o_rdata 0x12345678, o_rd=5.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit of the RV32I hart memory stage.
// Contents:
//   - funct3 encodings for load/store access size and signedness
//   - lsu_state_e: FSM state encoding (IDLE, REQ, WAIT)
package lsu_pkg;

  localparam logic [2:0] F3Byte  = 3'd0;  // LB / SB
  localparam logic [2:0] F3Half  = 3'd1;  // LH / SH
  localparam logic [2:0] F3Word  = 3'd2;  // LW / SW
  localparam logic [2:0] F3ByteU = 3'd4;  // LBU
  localparam logic [2:0] F3HalfU = 3'd5;  // LHU

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Bus bundle for load_store_unit: execute-side request, writeback-side result and
// the data-memory port.
// Modports:
//   master - LSU view (consumes execute/dmem inputs, drives result and dmem request)
//   slave  - environment view (execute, writeback and data memory)
interface lsu_if;
  // execute -> LSU
  logic        i_valid;
  logic        o_ready;
  logic        i_ren;
  logic        i_wen;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [4:0]  i_rd;
  // LSU -> writeback
  logic        o_valid;
  logic [4:0]  o_rd;
  logic [31:0] o_rdata;
  logic        o_trap;
  // data memory port
  logic [31:0] o_dmem_addr;
  logic        o_dmem_ren;
  logic        o_dmem_wen;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        i_dmem_ready;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;

  modport master (
    input  i_valid, i_ren, i_wen, i_funct3, i_addr, i_wdata, i_rd,
    input  i_dmem_ready, i_dmem_rvalid, i_dmem_rdata,
    output o_ready, o_valid, o_rd, o_rdata, o_trap,
    output o_dmem_addr, o_dmem_ren, o_dmem_wen, o_dmem_wdata, o_dmem_mask
  );

  modport slave (
    output i_valid, i_ren, i_wen, i_funct3, i_addr, i_wdata, i_rd,
    output i_dmem_ready, i_dmem_rvalid, i_dmem_rdata,
    input  o_ready, o_valid, o_rd, o_rdata, o_trap,
    input  o_dmem_addr, o_dmem_ren, o_dmem_wen, o_dmem_wdata, o_dmem_mask
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment helper for the load/store unit.
// Request side (live execute inputs):
//   funct3_i, offset_i, is_load_i, is_store_i, wdata_i -> mask_o, wdata_o, fault_o
// Response side (captured access):
//   ld_funct3_i, ld_offset_i, rdata_i -> ld_data_o (shifted and extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic        fault_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic        misalign;
  logic        illegal;
  logic [31:0] ld_shifted;

  always_comb begin
    misalign = 1'b0;
    mask_o   = 4'b1111;
    // funct3[1:0] is the access size for every legal encoding
    case (funct3_i[1:0])
      2'd0: mask_o = 4'b0001 << offset_i;
      2'd1: begin
        misalign = offset_i[0];
        mask_o   = offset_i[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: misalign = (offset_i != 2'd0);
      default: ;
    endcase

    illegal = 1'b0;
    if (is_load_i) begin
      illegal = (funct3_i == 3'd3) || (funct3_i >= 3'd6);
    end else if (is_store_i) begin
      illegal = (funct3_i >= 3'd3);
    end

    fault_o = (is_load_i || is_store_i) && (misalign || illegal);
    wdata_o = wdata_i << {offset_i, 3'b000};
  end

  always_comb begin
    ld_shifted = rdata_i >> {ld_offset_i, 3'b000};
    ld_data_o  = ld_shifted;
    case (ld_funct3_i)
      F3Byte:  ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3Half:  ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3Word:  ld_data_o = ld_shifted;
      F3ByteU: ld_data_o = {24'h0, ld_shifted[7:0]};
      F3HalfU: ld_data_o = {16'h0, ld_shifted[15:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the RV32I hart. Accepts one operation at a time from execute,
// issues an aligned request on the data-memory port (held until ready), waits for
// rvalid on loads and returns extended load data, a trap, or a pass-through value.
// Ports:
//   i_clk - clock
//   i_rst - synchronous active-high reset
//   bus   - lsu_if.master: execute request, writeback result, dmem port
module load_store_unit
  import lsu_pkg::*;
(
  input logic    i_clk,
  input logic    i_rst,
  lsu_if.master  bus
);

  lsu_state_e  state_q, state_d;
  logic        load_q, load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [4:0]  rd_q, rd_d;

  logic        valid_q, valid_d;
  logic        trap_q, trap_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic        dmem_ren_q, dmem_ren_d;
  logic        dmem_wen_q, dmem_wen_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_mask_q, dmem_mask_d;

  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        req_fault;
  logic [31:0] ld_data;

  lsu_align u_align (
    .funct3_i    (bus.i_funct3),
    .offset_i    (bus.i_addr[1:0]),
    .is_load_i   (bus.i_ren),
    .is_store_i  (bus.i_wen),
    .wdata_i     (bus.i_wdata),
    .mask_o      (req_mask),
    .wdata_o     (req_wdata),
    .fault_o     (req_fault),
    .ld_funct3_i (funct3_q),
    .ld_offset_i (offset_q),
    .rdata_i     (bus.i_dmem_rdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    rd_d         = rd_q;
    valid_d      = 1'b0;
    trap_d       = 1'b0;
    out_rd_d     = out_rd_q;
    rdata_d      = rdata_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_ren_d   = dmem_ren_q;
    dmem_wen_d   = dmem_wen_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_mask_d  = dmem_mask_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          if (!bus.i_ren && !bus.i_wen) begin
            valid_d  = 1'b1;
            out_rd_d = bus.i_rd;
            rdata_d  = bus.i_addr;
          end else if (req_fault) begin
            valid_d  = 1'b1;
            trap_d   = 1'b1;
            out_rd_d = 5'd0;
            rdata_d  = 32'h0;
          end else begin
            state_d      = StReq;
            load_d       = bus.i_ren;
            funct3_d     = bus.i_funct3;
            offset_d     = bus.i_addr[1:0];
            rd_d         = bus.i_rd;
            dmem_addr_d  = {bus.i_addr[31:2], 2'b00};
            dmem_ren_d   = bus.i_ren;
            dmem_wen_d   = bus.i_wen;
            dmem_wdata_d = req_wdata;
            dmem_mask_d  = req_mask;
          end
        end
      end
      StReq: begin
        if (bus.i_dmem_ready) begin
          dmem_ren_d = 1'b0;
          dmem_wen_d = 1'b0;
          if (load_q) begin
            state_d = StWait;
          end else begin
            state_d  = StIdle;
            valid_d  = 1'b1;
            out_rd_d = 5'd0;
            rdata_d  = 32'h0;
          end
        end
      end
      StWait: begin
        if (bus.i_dmem_rvalid) begin
          state_d  = StIdle;
          valid_d  = 1'b1;
          out_rd_d = rd_q;
          rdata_d  = ld_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      load_q       <= 1'b0;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
      rd_q         <= 5'd0;
      valid_q      <= 1'b0;
      trap_q       <= 1'b0;
      out_rd_q     <= 5'd0;
      rdata_q      <= 32'h0;
      dmem_addr_q  <= 32'h0;
      dmem_ren_q   <= 1'b0;
      dmem_wen_q   <= 1'b0;
      dmem_wdata_q <= 32'h0;
      dmem_mask_q  <= 4'h0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      rd_q         <= rd_d;
      valid_q      <= valid_d;
      trap_q       <= trap_d;
      out_rd_q     <= out_rd_d;
      rdata_q      <= rdata_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_ren_q   <= dmem_ren_d;
      dmem_wen_q   <= dmem_wen_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_mask_q  <= dmem_mask_d;
    end
  end

  assign bus.o_ready      = (state_q == StIdle);
  assign bus.o_valid      = valid_q;
  assign bus.o_trap       = trap_q;
  assign bus.o_rd         = out_rd_q;
  assign bus.o_rdata      = rdata_q;
  assign bus.o_dmem_addr  = dmem_addr_q;
  assign bus.o_dmem_ren   = dmem_ren_q;
  assign bus.o_dmem_wen   = dmem_wen_q;
  assign bus.o_dmem_wdata = dmem_wdata_q;
  assign bus.o_dmem_mask  = dmem_mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by random
// operations, all compared against a byte-arithmetic reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  lsu_if bus ();

  load_store_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int access_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit model_fault(input bit ren, input bit wen, input logic [2:0] f3,
                                     input logic [31:0] addr);
    bit legal;
    if (!ren && !wen) return 1'b0;
    legal = ren ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    if (!legal) return 1'b1;
    return (addr % access_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
    int n = access_bytes(f3);
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [31:0] addr);
    longint unsigned v = longint'(wdata);
    return 32'(v << (8 * (addr % 4)));
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int     n = access_bytes(f3);
    longint v = longint'(word);
    v = v >> (8 * (addr % 4));
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (f3 < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    end
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    bus.i_valid       = 1'b0;
    bus.i_ren         = 1'b0;
    bus.i_wen         = 1'b0;
    bus.i_dmem_ready  = 1'b0;
    bus.i_dmem_rvalid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction, entered #1 after an edge with the LSU idle.
  task automatic run_op(input bit ren, input bit wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int rdy_dly, input int rv_dly, input logic [31:0] mem_word,
                        output logic [31:0] got_rdata);
    bit fault = model_fault(ren, wen, f3, addr);
    chk("ready_idle", bus.o_ready, 1);
    bus.i_valid  = 1'b1;
    bus.i_ren    = ren;
    bus.i_wen    = wen;
    bus.i_funct3 = f3;
    bus.i_addr   = addr;
    bus.i_wdata  = wdata;
    bus.i_rd     = rd;
    step();
    idle_inputs();
    got_rdata = bus.o_rdata;
    if (fault) begin
      chk("trap_valid", bus.o_valid, 1);
      chk("trap_flag", bus.o_trap, 1);
      chk("trap_rd", bus.o_rd, 0);
      chk("trap_no_ren", bus.o_dmem_ren, 0);
      chk("trap_no_wen", bus.o_dmem_wen, 0);
      return;
    end
    if (!ren && !wen) begin
      chk("pass_valid", bus.o_valid, 1);
      chk("pass_rdata", bus.o_rdata, addr);
      chk("pass_rd", bus.o_rd, rd);
      chk("pass_trap", bus.o_trap, 0);
      return;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      chk("req_ren", bus.o_dmem_ren, ren);
      chk("req_wen", bus.o_dmem_wen, wen);
      chk("req_addr", bus.o_dmem_addr, addr & 32'hFFFF_FFFC);
      chk("req_mask", bus.o_dmem_mask, model_mask(f3, addr));
      if (wen) chk("req_wdata", bus.o_dmem_wdata, model_wdata(wdata, addr));
      chk("req_busy", bus.o_ready, 0);
      chk("req_novalid", bus.o_valid, 0);
      // unrelated traffic while busy must be ignored
      bus.i_dmem_ready  = (k == rdy_dly);
      bus.i_dmem_rvalid = (k < rdy_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_dmem_rdata  = $urandom;
      bus.i_valid       = 1'($urandom_range(0, 1));
      bus.i_ren         = 1'($urandom_range(0, 1));
      bus.i_wen         = !bus.i_ren;
      bus.i_funct3      = 3'($urandom_range(0, 7));
      bus.i_addr        = $urandom;
      bus.i_wdata       = $urandom;
      bus.i_rd          = 5'($urandom_range(0, 31));
      step();
      idle_inputs();
    end
    if (wen) begin
      chk("st_valid", bus.o_valid, 1);
      chk("st_rd", bus.o_rd, 0);
      chk("st_trap", bus.o_trap, 0);
      chk("st_ready", bus.o_ready, 1);
      chk("st_wen_drop", bus.o_dmem_wen, 0);
      got_rdata = bus.o_rdata;
      return;
    end
    for (int j = 0; j <= rv_dly; j++) begin
      chk("wait_ren_drop", bus.o_dmem_ren, 0);
      chk("wait_novalid", bus.o_valid, 0);
      chk("wait_busy", bus.o_ready, 0);
      bus.i_dmem_rvalid = (j == rv_dly);
      bus.i_dmem_rdata  = (j == rv_dly) ? mem_word : $urandom;
      step();
      idle_inputs();
    end
    chk("ld_valid", bus.o_valid, 1);
    chk("ld_rdata", bus.o_rdata, model_load(f3, addr, mem_word));
    chk("ld_rd", bus.o_rd, rd);
    chk("ld_trap", bus.o_trap, 0);
    chk("ld_ready", bus.o_ready, 1);
    got_rdata = bus.o_rdata;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, bus.o_ready, 1);
    chk({tag, "_valid"}, bus.o_valid, 0);
    chk({tag, "_trap"}, bus.o_trap, 0);
    chk({tag, "_rd"}, bus.o_rd, 0);
    chk({tag, "_rdata"}, bus.o_rdata, 0);
    chk({tag, "_ren"}, bus.o_dmem_ren, 0);
    chk({tag, "_wen"}, bus.o_dmem_wen, 0);
    chk({tag, "_addr"}, bus.o_dmem_addr, 0);
    chk({tag, "_wdata"}, bus.o_dmem_wdata, 0);
    chk({tag, "_mask"}, bus.o_dmem_mask, 0);
  endtask

  initial begin
    logic [31:0] got;
    idle_inputs();
    bus.i_funct3     = 3'd0;
    bus.i_addr       = 32'h0;
    bus.i_wdata      = 32'h0;
    bus.i_rd         = 5'd0;
    bus.i_dmem_rdata = 32'h0;
    rst = 1'b1;
    step();
    step();
    check_reset_values("rst");
    rst = 1'b0;
    step();

    // SB to byte lane 3, immediate ready
    run_op(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 5'd7, 0, 0, 32'h0, got);
    // LH / LHU from upper half, rvalid right after acceptance
    run_op(1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'h0, 5'd3, 0, 0, 32'h8001_1234, got);
    chk("lh_literal", got, 32'hFFFF_8001);
    run_op(1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'h0, 5'd3, 0, 0, 32'h8001_1234, got);
    chk("lhu_literal", got, 32'h0000_8001);
    // misaligned LW traps
    run_op(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0, 5'd9, 0, 0, 32'h0, got);
    // SW stalled three cycles
    run_op(1'b0, 1'b1, 3'd2, 32'h0000_4004, 32'hDEAD_BEEF, 5'd1, 3, 0, 32'h0, got);
    // pass-through
    run_op(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 0, 0, 32'h0, got);
    chk("pass_literal", got, 32'h1234_5678);
    // illegal store funct3
    run_op(1'b0, 1'b1, 3'd3, 32'h0000_5000, 32'h1, 5'd2, 0, 0, 32'h0, got);
    // LB sign-extend from lane 1
    run_op(1'b1, 1'b0, 3'd0, 32'h0000_6001, 32'h0, 5'd4, 1, 2, 32'h0000_F000, got);
    chk("lb_literal", got, 32'hFFFF_FFF0);

    // reset during WAIT, then a late rvalid
    bus.i_valid = 1'b1; bus.i_ren = 1'b1; bus.i_funct3 = 3'd2;
    bus.i_addr = 32'h0000_7000; bus.i_rd = 5'd6;
    step();
    idle_inputs();
    bus.i_dmem_ready = 1'b1;
    step();
    bus.i_dmem_ready = 1'b0;
    chk("rw_in_wait", bus.o_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("rst_wait");
    bus.i_dmem_rvalid = 1'b1;
    bus.i_dmem_rdata  = 32'hCAFE_F00D;
    step();
    bus.i_dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rvalid_novalid", bus.o_valid, 0);
      chk("late_rvalid_ready", bus.o_ready, 1);
      step();
    end

    // reset during REQ drops the write request
    bus.i_valid = 1'b1; bus.i_wen = 1'b1; bus.i_funct3 = 3'd2;
    bus.i_addr = 32'h0000_8000; bus.i_wdata = 32'h5555_AAAA; bus.i_rd = 5'd8;
    step();
    idle_inputs();
    chk("rr_wen_up", bus.o_dmem_wen, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("rst_req");
    step();
    chk("rr_novalid", bus.o_valid, 0);

    // random operations, back to back
    for (int t = 0; t < 200; t++) begin
      int          kind = $urandom_range(0, 4);
      bit          ren  = (kind <= 1);
      bit          wen  = (kind == 2 || kind == 3);
      logic [31:0] addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_op(ren, wen, 3'($urandom_range(0, 7)), addr, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, got);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
